fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arb.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter.
package fifo_wr_arb_pkg;

    localparam int unsigned DEF_DATA_W    = 4;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Increment that stops at the burst limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter into a FIFO with bounded ownership bursts.
// Grants and FIFO write are combinational; ownership state is registered.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_e           state;
    state_e           state_n;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_n;
    logic             last;
    logic             last_n;
    logic             win_vld;
    logic             win_id;
    logic             xfer;

    // Winner selection: the owner keeps the port until its burst is spent
    // while the other side waits; IDLE ties go to the side not served last.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
        case (state)
            OWN0: begin
                if (req0 && ((burst_cnt < MAX_CNT) || !req1)) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
            OWN1: begin
                if (req1 && ((burst_cnt < MAX_CNT) || !req0)) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end
            end
            default: begin
                if (req0 && req1) begin
                    win_vld = 1'b1;
                    win_id  = ~last;
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
        endcase
    end

    // Zero-latency write path, forced quiet while reset is asserted.
    always_comb begin
        xfer       = win_vld & ~fifo_full & reset;
        gnt0       = xfer & ~win_id;
        gnt1       = xfer & win_id;
        fifo_wr    = xfer;
        fifo_wdata = xfer ? (win_id ? wdata1 : wdata0) : '0;
    end

    // Ownership update; a full FIFO freezes everything.
    always_comb begin
        state_n     = state;
        burst_cnt_n = burst_cnt;
        last_n      = last;
        if (!fifo_full) begin
            if (win_vld) begin
                if ((state == IDLE) || (win_id != (state == OWN1))) begin
                    state_n     = win_id ? OWN1 : OWN0;
                    burst_cnt_n = CNT_W'(1);
                    last_n      = win_id;
                end else begin
                    burst_cnt_n = sat_inc(burst_cnt, MAX_CNT);
                end
            end else begin
                state_n     = IDLE;
                burst_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last      <= 1'b1;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            state     <= state_n;
            burst_cnt <= burst_cnt_n;
            last      <= last_n;
            busy      <= (state_n != IDLE);
            owner     <= (state_n == OWN1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized
// traffic compared every cycle against a behavioural ownership model.
module tb_fifo_wr_arb;

    localparam int unsigned DATA_W    = 4;
    localparam int          MAX_BURST = 4;

    logic              clk;
    logic              reset;
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              owner;
    logic              busy;

    int n_total;
    int n_pass;

    fifo_wr_arb #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .owner(owner), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Model state: m_own = -1 idle, else owning requester index.
    int m_own;
    int m_cnt;
    int m_last;

    initial begin
        int win;
        int o;
        logic [DATA_W-1:0] e_data;
        m_own = -1; m_cnt = 0; m_last = 1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_own = -1; m_cnt = 0; m_last = 1;
                chk("rst_gnt0", 32'(gnt0), 0);
                chk("rst_gnt1", 32'(gnt1), 0);
                chk("rst_wr", 32'(fifo_wr), 0);
                chk("rst_wdata", 32'(fifo_wdata), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_owner", 32'(owner), 0);
            end else begin
                win = -1;
                if (m_own >= 0) begin
                    o = m_own;
                    if (((o == 0) ? req0 : req1) && (m_cnt < MAX_BURST || !((o == 0) ? req1 : req0)))
                        win = o;
                    else if ((o == 0) ? req1 : req0)
                        win = 1 - o;
                end else if (req0 && req1) win = 1 - m_last;
                else if (req0) win = 0;
                else if (req1) win = 1;
                if (win >= 0 && !fifo_full) e_data = (win == 0) ? wdata0 : wdata1;
                else e_data = '0;
                chk("gnt0", 32'(gnt0), 32'(win == 0 && !fifo_full));
                chk("gnt1", 32'(gnt1), 32'(win == 1 && !fifo_full));
                chk("fifo_wr", 32'(fifo_wr), 32'(win >= 0 && !fifo_full));
                chk("fifo_wdata", 32'(fifo_wdata), 32'(e_data));
                chk("busy", 32'(busy), 32'(m_own >= 0));
                chk("owner", 32'(owner), 32'(m_own == 1));
                if (!fifo_full) begin
                    if (win < 0) begin
                        m_own = -1; m_cnt = 0;
                    end else if (win != m_own) begin
                        m_own = win; m_cnt = 1; m_last = win;
                    end else if (m_cnt < MAX_BURST) begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic step(input logic r0, input logic r1, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1, input logic full);
        @(posedge clk);
        #1;
        reset = 1'b1; req0 = r0; req1 = r1; wdata0 = d0; wdata1 = d1; fifo_full = full;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_wr", 32'(fifo_wr), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] pat [10];
        logic [DATA_W-1:0] alt [4];
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; wdata0 = 4'h3; wdata1 = 4'hC; fifo_full = 1'b0;
        #2;
        chk("por_gnt0", 32'(gnt0), 0);
        chk("por_wdata", 32'(fifo_wdata), 0);
        @(negedge clk);
        @(negedge clk);

        // Release with both requesting: requester 0 first, then 4/4 bursts.
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 4'h3, 4'hC, 1'b0);
            chk($sformatf("pattern_%0d", i), 32'({gnt1, gnt0}), 32'(pat[i]));
            if (i == 0) chk("first_wdata", 32'(fifo_wdata), 32'h3);
        end

        // Alternating single requests.
        do_reset();
        alt = '{4'hA, 4'h5, 4'hA, 4'h5};
        for (int i = 0; i < 4; i++) begin
            step(i % 2 == 0, i % 2 == 1, 4'hA, 4'h5, 1'b0);
            chk($sformatf("alt_wdata_%0d", i), 32'(fifo_wdata), 32'(alt[i]));
            chk($sformatf("alt_gnt_%0d", i), 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Lone requester past saturation, then drop.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'h0, 4'(i), 1'b0);
            chk($sformatf("solo_gnt1_%0d", i), 32'(gnt1), 1);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("solo_busy_hold", 32'(busy), 1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("solo_busy_drop", 32'(busy), 0);

        // Full stall mid-burst holds ownership and count.
        do_reset();
        step(1'b1, 1'b0, 4'h1, 4'h9, 1'b0);
        step(1'b1, 1'b0, 4'h2, 4'h9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'h7, 4'h9, 1'b1);
            chk($sformatf("full_nogrant_%0d", i), 32'(fifo_wr), 0);
            chk($sformatf("full_owner_%0d", i), 32'({busy, owner}), 32'd2);
        end
        step(1'b1, 1'b1, 4'h3, 4'h9, 1'b0);
        chk("after_full_w3", 32'({gnt1, gnt0}), 1);
        step(1'b1, 1'b1, 4'h4, 4'h9, 1'b0);
        chk("after_full_w4", 32'({gnt1, gnt0}), 1);
        step(1'b1, 1'b1, 4'h5, 4'h9, 1'b0);
        chk("after_full_switch", 32'({gnt1, gnt0}), 2);
        chk("after_full_wdata", 32'(fifo_wdata), 32'h9);

        // Asynchronous reset in the middle of an OWN1 burst.
        step(1'b0, 1'b1, 4'h0, 4'h6, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h6, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt1", 32'(gnt1), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_wdata", 32'(fifo_wdata), 0);
        @(negedge clk);
        step(1'b1, 1'b1, 4'hE, 4'h6, 1'b0);
        chk("post_rst_gnt0", 32'({gnt1, gnt0}), 1);

        // Random traffic with occasional full and reset pulses.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            reset     = ($urandom_range(0, 59) != 0);
            req0      = ($urandom_range(0, 3) != 0);
            req1      = ($urandom_range(0, 3) != 0);
            wdata0    = 4'($urandom);
            wdata1    = 4'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
